// File: rtl/gtech_idle_pkg.sv
// Shared definitions for the request-line inactivity timer: FSM encoding and
// the default counter width.
package gtech_idle_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'b00,
    ST_COUNT  = 2'b01,
    ST_IDLE   = 2'b10
  } state_e;

  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/gtech_idle_timer_nor8.sv
// 8-input NOR reduction; drives the all-quiet flag from the sampled request lines.
module GTECH_NOR8
  import gtech_idle_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic E,
  input  logic F,
  input  logic G,
  input  logic H,
  output logic Z
);

  assign Z = ~(A | B | C | D | E | F | G | H);

endmodule

// File: rtl/gtech_idle_timer.sv
// Registered inactivity detector: asserts IDLE after THRESH consecutive quiet
// cycles on REQ, with one-cycle TIMEOUT (entry) and WAKE (activity exit) pulses.
module gtech_idle_timer
  import gtech_idle_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CP,
  input  logic             CD,
  input  logic [7:0]       REQ,
  input  logic             EN,
  input  logic             CLR,
  input  logic [CNT_W-1:0] THRESH,
  output logic             IDLE,
  output logic             TIMEOUT,
  output logic             WAKE,
  output logic [CNT_W-1:0] CNT
);

  logic [7:0]       req_q;
  logic             quiet;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, nxt;
  logic             idle_q, idle_d;
  logic             timeout_q, timeout_d;
  logic             wake_q, wake_d;
  logic             hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Sample stage: request lines registered before the zero-detect
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      req_q <= '0;
    end else begin
      req_q <= REQ;
    end
  end

  GTECH_NOR8 u_nor8 (
    .A (req_q[0]),
    .B (req_q[1]),
    .C (req_q[2]),
    .D (req_q[3]),
    .E (req_q[4]),
    .F (req_q[5]),
    .G (req_q[6]),
    .H (req_q[7]),
    .Z (quiet)
  );

  assign nxt = sat_inc(cnt_q);
  // THRESH of zero disables the timeout; >= tolerates THRESH dropping mid-count
  assign hit = (THRESH != '0) && (nxt >= THRESH);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    wake_d    = 1'b0;
    if (CLR || !EN) begin
      state_d = ST_ACTIVE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_ACTIVE: begin
          if (quiet) begin
            cnt_d = nxt;
            if (hit) begin
              state_d   = ST_IDLE;
              timeout_d = 1'b1;
            end else begin
              state_d = ST_COUNT;
            end
          end else begin
            cnt_d = '0;
          end
        end
        ST_COUNT: begin
          if (!quiet) begin
            state_d = ST_ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = nxt;
            if (hit) begin
              state_d   = ST_IDLE;
              timeout_d = 1'b1;
            end
          end
        end
        ST_IDLE: begin
          if (!quiet) begin
            state_d = ST_ACTIVE;
            cnt_d   = '0;
            wake_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end
      endcase
    end
    idle_d = (state_d == ST_IDLE);
  end

  // Control stage: FSM, counter and registered outputs
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      state_q   <= ST_ACTIVE;
      cnt_q     <= '0;
      idle_q    <= 1'b0;
      timeout_q <= 1'b0;
      wake_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
      wake_q    <= wake_d;
    end
  end

  assign IDLE    = idle_q;
  assign TIMEOUT = timeout_q;
  assign WAKE    = wake_q;
  assign CNT     = cnt_q;

endmodule

// File: tb/tb_gtech_idle_timer.sv
// Directed bench for gtech_idle_timer: vector table plus hand-written corner sequences.
module tb_gtech_idle_timer;

  logic       CP;
  logic       CD;
  logic [7:0] REQ;
  logic       EN;
  logic       CLR;
  logic [7:0] THRESH;
  logic       IDLE, TIMEOUT, WAKE;
  logic [7:0] CNT;

  logic [3:0] thr4;
  logic       IDLE4, TIMEOUT4, WAKE4;
  logic [3:0] CNT4;

  assign thr4 = THRESH[3:0];

  gtech_idle_timer #(.CNT_W(8)) dut (
    .CP(CP), .CD(CD), .REQ(REQ), .EN(EN), .CLR(CLR), .THRESH(THRESH),
    .IDLE(IDLE), .TIMEOUT(TIMEOUT), .WAKE(WAKE), .CNT(CNT)
  );

  gtech_idle_timer #(.CNT_W(4)) dut4 (
    .CP(CP), .CD(CD), .REQ(REQ), .EN(EN), .CLR(CLR), .THRESH(thr4),
    .IDLE(IDLE4), .TIMEOUT(TIMEOUT4), .WAKE(WAKE4), .CNT(CNT4)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  typedef struct {
    logic [7:0] req;
    logic       en;
    logic       clr;
    logic [7:0] thr;
    logic       idle;
    logic       to;
    logic       wake;
    logic [7:0] cnt;
  } vec_t;

  localparam int NV = 33;
  vec_t vt [NV];
  int   nv_fill;
  int   n_tests;
  int   n_fail;

  task automatic add(input logic [7:0] req, input logic en, input logic clr,
                     input logic [7:0] thr, input logic idle, input logic to,
                     input logic wake, input logic [7:0] cnt);
    vt[nv_fill].req  = req;
    vt[nv_fill].en   = en;
    vt[nv_fill].clr  = clr;
    vt[nv_fill].thr  = thr;
    vt[nv_fill].idle = idle;
    vt[nv_fill].to   = to;
    vt[nv_fill].wake = wake;
    vt[nv_fill].cnt  = cnt;
    nv_fill++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic idle, input logic to,
                         input logic wake, input logic [7:0] cnt);
    chk({nm, ".IDLE"},    {31'd0, IDLE},    {31'd0, idle});
    chk({nm, ".TIMEOUT"}, {31'd0, TIMEOUT}, {31'd0, to});
    chk({nm, ".WAKE"},    {31'd0, WAKE},    {31'd0, wake});
    chk({nm, ".CNT"},     {24'd0, CNT},     {24'd0, cnt});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  seen_idle;
    int  seen_to;
    n_tests = 0;
    n_fail  = 0;
    nv_fill = 0;

    //   req    en  clr thr    idle to wake cnt
    add(8'h03, 0, 0, 8'd4,   0, 0, 0, 8'd0);
    add(8'h00, 1, 0, 8'd4,   0, 0, 0, 8'd0);
    add(8'h00, 1, 0, 8'd4,   0, 0, 0, 8'd1);
    add(8'h00, 1, 0, 8'd4,   0, 0, 0, 8'd2);
    add(8'h00, 1, 0, 8'd4,   0, 0, 0, 8'd3);
    add(8'h00, 1, 0, 8'd4,   1, 1, 0, 8'd4);
    add(8'h00, 1, 0, 8'd4,   1, 0, 0, 8'd4);
    add(8'h40, 1, 0, 8'd4,   1, 0, 0, 8'd4);
    add(8'h00, 1, 0, 8'd4,   0, 0, 1, 8'd0);
    add(8'h00, 1, 0, 8'd4,   0, 0, 0, 8'd1);
    add(8'h00, 1, 0, 8'd4,   0, 0, 0, 8'd2);
    add(8'h01, 1, 0, 8'd6,   0, 0, 0, 8'd3);
    add(8'h00, 1, 0, 8'd6,   0, 0, 0, 8'd0);
    add(8'h00, 1, 0, 8'd6,   0, 0, 0, 8'd1);
    add(8'h00, 1, 0, 8'd6,   0, 0, 0, 8'd2);
    add(8'h00, 1, 0, 8'd6,   0, 0, 0, 8'd3);
    add(8'h00, 1, 0, 8'd6,   0, 0, 0, 8'd4);
    add(8'h00, 1, 0, 8'd6,   0, 0, 0, 8'd5);
    add(8'h00, 1, 0, 8'd6,   1, 1, 0, 8'd6);
    add(8'h00, 1, 0, 8'd6,   1, 0, 0, 8'd6);
    add(8'hFF, 1, 0, 8'd6,   1, 0, 0, 8'd6);
    add(8'hFF, 1, 1, 8'd6,   0, 0, 0, 8'd0);
    add(8'h00, 1, 0, 8'd10,  0, 0, 0, 8'd0);
    add(8'h00, 1, 0, 8'd10,  0, 0, 0, 8'd1);
    add(8'h00, 1, 0, 8'd10,  0, 0, 0, 8'd2);
    add(8'h00, 1, 0, 8'd10,  0, 0, 0, 8'd3);
    add(8'h00, 1, 0, 8'd10,  0, 0, 0, 8'd4);
    add(8'h00, 1, 0, 8'd10,  0, 0, 0, 8'd5);
    add(8'h00, 1, 0, 8'd2,   1, 1, 0, 8'd6);
    add(8'h00, 1, 0, 8'd2,   1, 0, 0, 8'd6);
    add(8'h00, 0, 0, 8'd2,   0, 0, 0, 8'd0);
    add(8'h00, 1, 0, 8'd1,   1, 1, 0, 8'd1);
    add(8'h00, 1, 0, 8'd1,   1, 0, 0, 8'd1);

    CD     = 1'b0;
    REQ    = 8'h00;
    EN     = 1'b0;
    CLR    = 1'b0;
    THRESH = 8'd0;
    repeat (2) tick();
    chk_all("reset", 0, 0, 0, 8'd0);
    @(negedge CP);
    CD = 1'b1;

    for (int i = 0; i < NV; i++) begin
      REQ    = vt[i].req;
      EN     = vt[i].en;
      CLR    = vt[i].clr;
      THRESH = vt[i].thr;
      tick();
      chk_all($sformatf("v%0d", i), vt[i].idle, vt[i].to, vt[i].wake, vt[i].cnt);
    end

    // THRESH=0: count saturates in the 4-bit instance, never idles
    CLR = 1'b1; THRESH = 8'd0; REQ = 8'h00; EN = 1'b1;
    tick();
    chk("sat.clr.CNT", {24'd0, CNT}, 32'd0);
    chk("sat.clr.IDLE", {31'd0, IDLE}, 32'd0);
    CLR = 1'b0;
    seen_idle = 0;
    seen_to   = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (IDLE || IDLE4) seen_idle++;
      if (TIMEOUT || TIMEOUT4) seen_to++;
    end
    chk("sat.CNT8", {24'd0, CNT}, 32'd20);
    chk("sat.CNT4", {28'd0, CNT4}, 32'd15);
    chk("sat.idle_cycles", seen_idle, 0);
    chk("sat.timeout_cycles", seen_to, 0);

    // Asynchronous reset mid-count
    CLR = 1'b1; THRESH = 8'd10;
    tick();
    CLR = 1'b0;
    repeat (3) tick();
    chk("arst1.pre.CNT", {24'd0, CNT}, 32'd3);
    #2 CD = 1'b0;
    #1;
    chk_all("arst1", 0, 0, 0, 8'd0);
    @(negedge CP);
    CD = 1'b1;

    // Asynchronous reset while TIMEOUT is high
    THRESH = 8'd2;
    tick();
    chk("arst2.c1.CNT", {24'd0, CNT}, 32'd1);
    tick();
    chk("arst2.pre.TIMEOUT", {31'd0, TIMEOUT}, 32'd1);
    chk("arst2.pre.IDLE", {31'd0, IDLE}, 32'd1);
    #2 CD = 1'b0;
    #1;
    chk_all("arst2", 0, 0, 0, 8'd0);
    @(negedge CP);
    CD  = 1'b1;
    REQ = 8'hFF;
    tick();
    tick();
    chk_all("arst2.after", 0, 0, 0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
